// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer: FSM state encoding,
// PC-source select codes, cause codes and the overflow bit position.
package exception_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        RETURN  = 2'd2
    } exc_state_t;

    localparam logic [1:0] PC_SEL_NORMAL  = 2'b00;
    localparam logic [1:0] PC_SEL_HANDLER = 2'b01;
    localparam logic [1:0] PC_SEL_EPC     = 2'b10;

    localparam logic CAUSE_OVF   = 1'b1;
    localparam logic CAUSE_UNDEF = 1'b0;

    localparam int OVF_BIT = 1;

endpackage

// File: rtl/exception_sequencer_exc_sat_counter.sv
// Saturating up-counter: advances by one per enabled cycle and sticks at all-ones.
module exc_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception controller for the 5-stage MIPS pipeline: flush/redirect, EPC/Cause capture, ERET return.
// Optional per-type exception statistics counters are enabled with the EXC_STATS_EN macro.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          FLAG_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FLAG_WIDTH-1:0] flag_ex,
    input  logic                  undef_id,
    input  logic                  eret_id,
    input  logic [31:0]           pc_ex,
    input  logic [31:0]           pc_id,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            pc_sel,
    output logic [31:0]           pc_target,
    output logic [31:0]           epc,
    output logic [1:0]            cause,
    output logic                  exl,
    output logic [3:0]            masked_cnt
`ifdef EXC_STATS_EN
    ,
    output logic [15:0]           ovf_count,
    output logic [15:0]           undef_count
`endif
);

    exc_state_t state;
    logic       is_ovf;
    logic       any_flag;
    logic       take_exc;
    logic       masked_inc;
    logic       unused_flags;

    assign is_ovf       = flag_ex[OVF_BIT];
    assign any_flag     = is_ovf | undef_id;
    assign unused_flags = ^flag_ex;
    assign masked_inc   = (state != IDLE) & any_flag;

    // Redirect and flushes are combinational so the faulting instruction never commits;
    // reset forces them inactive without waiting for an edge.
    always_comb begin
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = PC_SEL_NORMAL;
        pc_target    = 32'h0;
        take_exc     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // An ERET outside the handler is treated as an undefined instruction.
                    if (is_ovf || undef_id || eret_id) begin
                        take_exc     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = is_ovf;
                        pc_sel       = PC_SEL_HANDLER;
                        pc_target    = HANDLER_ADDR;
                    end
                end
                HANDLER: begin
                    if (eret_id) begin
                        if_id_flush = 1'b1;
                        pc_sel      = PC_SEL_EPC;
                        pc_target   = epc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            epc   <= 32'h0;
            cause <= 2'b00;
            exl   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_exc) begin
                        // Overflow is in the older instruction, so it wins over ID-stage flags.
                        epc   <= (is_ovf ? pc_ex : pc_id) - 32'd4;
                        cause <= {1'b1, (is_ovf ? CAUSE_OVF : CAUSE_UNDEF)};
                        exl   <= 1'b1;
                        state <= HANDLER;
                    end
                end
                HANDLER: begin
                    if (eret_id) begin
                        state <= RETURN;
                    end
                end
                RETURN: begin
                    exl      <= 1'b0;
                    cause[1] <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    exc_sat_counter #(.WIDTH(4)) u_masked_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (masked_inc),
        .count (masked_cnt)
    );

`ifdef EXC_STATS_EN
    exc_sat_counter #(.WIDTH(16)) u_ovf_count (
        .clk   (clk),
        .reset (reset),
        .inc   (take_exc & is_ovf),
        .count (ovf_count)
    );

    exc_sat_counter #(.WIDTH(16)) u_undef_count (
        .clk   (clk),
        .reset (reset),
        .inc   (take_exc & ~is_ovf),
        .count (undef_count)
    );
`endif

endmodule
